xilly_stream_exerciser: RTL and testbench

- Synthesizable, parametrised stimulus/response engine for the Xillybus 32-bit stream pair feeding the overlay accelerator top.
- Opens the write stream and waits a fixed schedule-load interval.
- Streams a repeating ramp pattern for N frames, honouring FIFO backpressure.
- Drains the read stream concurrently, reporting word count, checksum and timeout status.
- Replaces hand-written per-word bench stimulus; usable on-chip for self-test.

---
 rtl/xilly_stream_exerciser_pkg.sv | 20 ++
 rtl/xilly_stream_exerciser_if.sv | 23 ++
 rtl/xilly_stream_exerciser_rx_capture.sv | 61 ++++++
 rtl/xilly_stream_exerciser.sv | 137 +++++++++++++
 tb/tb_xilly_stream_exerciser.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/xilly_stream_exerciser_pkg.sv
// Shared types and sizing helpers for the Xillybus stream exerciser.
package xilly_exr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPEN_WAIT,
    S_STREAM,
    S_DRAIN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  // Wide enough to hold the larger of the write and read totals.
  function automatic int cnt_width(input int total_wr, input int expect_rd);
    int m;
    m = (total_wr > expect_rd) ? total_wr : expect_rd;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/xilly_stream_exerciser_if.sv
// Xillybus 32-bit stream pair: write stream toward the FIFO, read stream back.
interface xilly_stream_exerciser_if #(
  parameter int DATA_W = 32
);
  logic              w_open;
  logic [DATA_W-1:0] w_data;
  logic              w_wren;
  logic              w_full;
  logic              r_open;
  logic              r_rden;
  logic [DATA_W-1:0] r_data;
  logic              r_empty;

  modport master (
    output w_open, w_data, w_wren, r_open, r_rden,
    input  w_full, r_data, r_empty
  );

  modport slave (
    input  w_open, w_data, w_wren, r_open, r_rden,
    output w_full, r_data, r_empty
  );
endinterface

// File: rtl/xilly_stream_exerciser_rx_capture.sv
// Read-side engine: read strobes, one-cycle-late capture, word count,
// running checksum and the DRAIN idle timer.
module xilly_exr_rx_capture #(
  parameter int DATA_W       = 32,
  parameter int EXPECT_WORDS = 33,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int CNT_W        = 6
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic              clear,
  input  logic              en,
  input  logic              drain,
  input  logic              r_empty,
  input  logic [DATA_W-1:0] r_data,
  output logic              r_rden,
  output logic [CNT_W-1:0]  words_recv,
  output logic [DATA_W-1:0] rx_sum,
  output logic              complete,
  output logic              timeout_hit
);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] reads_issued;
  logic             rden_d;
  logic [TMO_W-1:0] idle_cnt;

  assign r_rden      = en && !r_empty && (reads_issued < CNT_W'(EXPECT_WORDS));
  assign complete    = (words_recv == CNT_W'(EXPECT_WORDS));
  // A capture in the expiry cycle reloads the timer instead of timing out.
  assign timeout_hit = drain && !rden_d && (idle_cnt == '0);

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      reads_issued <= '0;
      rden_d       <= 1'b0;
      words_recv   <= '0;
      rx_sum       <= '0;
      idle_cnt     <= '0;
    end else if (clear) begin
      reads_issued <= '0;
      rden_d       <= 1'b0;
      words_recv   <= '0;
      rx_sum       <= '0;
      idle_cnt     <= TMO_W'(TIMEOUT_CYC - 1);
    end else begin
      rden_d <= r_rden;
      if (r_rden && reads_issued != '1)
        reads_issued <= reads_issued + CNT_W'(1);
      if (rden_d) begin
        if (words_recv != '1)
          words_recv <= words_recv + CNT_W'(1);
        rx_sum <= rx_sum + r_data;
      end
      if (rden_d || !drain)
        idle_cnt <= TMO_W'(TIMEOUT_CYC - 1);
      else if (idle_cnt != '0)
        idle_cnt <= idle_cnt - TMO_W'(1);
    end
  end
endmodule

// File: rtl/xilly_stream_exerciser.sv
// Stream exerciser: opens the write stream, writes a repeating ramp under
// backpressure and drains/checksums the read stream concurrently.
//
//   state       | meaning
//   S_IDLE      | waiting for start, all outputs low
//   S_OPEN_WAIT | write stream open, waiting out schedule load
//   S_STREAM    | writing ramp frames, reading concurrently
//   S_DRAIN     | all writes done, collecting remaining reads
//   S_DONE      | all expected reads captured
//   S_TIMEOUT   | read stream went idle too long
module xilly_stream_exerciser
  import xilly_exr_pkg::*;
#(
  parameter int  DATA_W       = 32,
  parameter int  PATTERN_LEN  = 11,
  parameter int  NUM_FRAMES   = 3,
  parameter int  OPEN_WAIT    = 10,
  parameter int  EXPECT_WORDS = 33,
  parameter int  TIMEOUT_CYC  = 1000,
  localparam int CNT_W        = cnt_width(NUM_FRAMES * PATTERN_LEN, EXPECT_WORDS)
) (
  input  logic                      bus_clk,
  input  logic                      bus_rst,
  input  logic                      start,
  xilly_stream_exerciser_if.master  xs,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic [CNT_W-1:0]          words_sent,
  output logic [CNT_W-1:0]          words_recv,
  output logic [DATA_W-1:0]         rx_sum
);
  localparam int TOTAL_WR = NUM_FRAMES * PATTERN_LEN;
  localparam int OW_W     = $clog2(OPEN_WAIT + 1);
  localparam int IDX_W    = $clog2(PATTERN_LEN + 1);
  localparam int FR_W     = $clog2(NUM_FRAMES + 1);

  state_t            state, state_nxt;
  logic [OW_W-1:0]   ow_cnt;
  logic [IDX_W-1:0]  pat_idx;
  logic [FR_W-1:0]   frame_cnt;
  logic [CNT_W-1:0]  words_sent_q;
  logic [DATA_W-1:0] w_data_q;
  logic              w_accept, last_word;
  logic              rx_clear, rx_en, rx_drain, rx_complete, rx_timeout;

  assign w_accept  = (state == S_STREAM) && !xs.w_full && (words_sent_q < CNT_W'(TOTAL_WR));
  assign last_word = (pat_idx == IDX_W'(PATTERN_LEN - 1)) && (frame_cnt == FR_W'(NUM_FRAMES - 1));
  assign rx_en     = (state == S_STREAM) || (state == S_DRAIN);
  assign rx_drain  = (state == S_DRAIN);

  assign xs.w_wren = w_accept;
  assign xs.w_data = w_data_q;
  assign xs.w_open = busy;
  assign xs.r_open = rx_en;
  assign busy       = (state == S_OPEN_WAIT) || rx_en;
  assign done       = (state == S_DONE) || (state == S_TIMEOUT);
  assign timeout    = (state == S_TIMEOUT);
  assign words_sent = words_sent_q;

  always_comb begin
    state_nxt = state;
    rx_clear  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          state_nxt = S_OPEN_WAIT;
          rx_clear  = 1'b1;
        end
      end
      S_OPEN_WAIT: if (ow_cnt == '0) state_nxt = S_STREAM;
      // Reads finishing early never cut the write stream short.
      S_STREAM:    if (w_accept && last_word) state_nxt = rx_complete ? S_DONE : S_DRAIN;
      S_DRAIN: begin
        if (rx_complete)     state_nxt = S_DONE;
        else if (rx_timeout) state_nxt = S_TIMEOUT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state        <= S_IDLE;
      ow_cnt       <= '0;
      pat_idx      <= '0;
      frame_cnt    <= '0;
      words_sent_q <= '0;
      w_data_q     <= '0;
    end else begin
      state <= state_nxt;
      if (rx_clear) begin
        ow_cnt       <= OW_W'(OPEN_WAIT - 1);
        pat_idx      <= '0;
        frame_cnt    <= '0;
        words_sent_q <= '0;
        w_data_q     <= DATA_W'(1);
      end else begin
        if (state == S_OPEN_WAIT && ow_cnt != '0)
          ow_cnt <= ow_cnt - OW_W'(1);
        if (w_accept) begin
          if (words_sent_q != '1)
            words_sent_q <= words_sent_q + CNT_W'(1);
          if (pat_idx == IDX_W'(PATTERN_LEN - 1)) begin
            pat_idx  <= '0;
            w_data_q <= DATA_W'(1);
            if (frame_cnt != '1)
              frame_cnt <= frame_cnt + FR_W'(1);
          end else begin
            pat_idx  <= pat_idx + IDX_W'(1);
            w_data_q <= DATA_W'(pat_idx) + DATA_W'(2);
          end
        end
      end
    end
  end

  xilly_exr_rx_capture #(
    .DATA_W       (DATA_W),
    .EXPECT_WORDS (EXPECT_WORDS),
    .TIMEOUT_CYC  (TIMEOUT_CYC),
    .CNT_W        (CNT_W)
  ) u_rx (
    .bus_clk     (bus_clk),
    .bus_rst     (bus_rst),
    .clear       (rx_clear),
    .en          (rx_en),
    .drain       (rx_drain),
    .r_empty     (xs.r_empty),
    .r_data      (xs.r_data),
    .r_rden      (xs.r_rden),
    .words_recv  (words_recv),
    .rx_sum      (rx_sum),
    .complete    (rx_complete),
    .timeout_hit (rx_timeout)
  );
endmodule

// File: tb/tb_xilly_stream_exerciser.sv
// Bench for xilly_stream_exerciser: loopback FIFO model, table of runs with
// fixed and random backpressure, stuck-empty timeout and mid-run reset.
module tb_xilly_stream_exerciser;
  import xilly_exr_pkg::*;

  localparam int DATA_W = 32;
  localparam int PL     = 11;
  localparam int NF     = 3;
  localparam int OW     = 10;
  localparam int EXP    = 33;
  localparam int TMO    = 1000;
  localparam int TOTAL  = NF * PL;
  localparam int CNT_W  = cnt_width(TOTAL, EXP);

  logic              bus_clk = 1'b0;
  logic              bus_rst = 1'b1;
  logic              start   = 1'b0;
  logic              busy, done, timeout;
  logic [CNT_W-1:0]  words_sent, words_recv;
  logic [DATA_W-1:0] rx_sum;

  xilly_stream_exerciser_if #(.DATA_W(DATA_W)) xs ();

  xilly_stream_exerciser #(
    .DATA_W(DATA_W), .PATTERN_LEN(PL), .NUM_FRAMES(NF),
    .OPEN_WAIT(OW), .EXPECT_WORDS(EXP), .TIMEOUT_CYC(TMO)
  ) dut (
    .bus_clk    (bus_clk),
    .bus_rst    (bus_rst),
    .start      (start),
    .xs         (xs),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .words_sent (words_sent),
    .words_recv (words_recv),
    .rx_sum     (rx_sum)
  );

  always #5 bus_clk = ~bus_clk;

  typedef struct {
    int full_mode;    // 0 never full, 1 toggling, 2 random (+ random read stalls)
    bit stuck;        // r_empty held high
    int rst_after;    // >0: reset after this many accepted writes
    int poke_at;      // >0: extra start pulse at this loop cycle
    bit check_timing;
    bit exp_to;
    int exp_sent;
    int exp_recv;
    int exp_sum;
  } vec_t;

  vec_t vecs[10];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Loopback FIFO model and run bookkeeping
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] pending;
  bit                have_pending;
  int                n_wr, phase, last_wr_phase, first_wr_phase, first_open_phase;
  int                full_mode;
  bit                stuck;
  bit                start_req, rst_req;
  int                ramp_sum;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  task automatic step();
    @(negedge bus_clk);
    start   = start_req;
    bus_rst = rst_req;
    case (full_mode)
      0:       xs.w_full = 1'b0;
      1:       xs.w_full = phase[0];
      default: xs.w_full = 1'($urandom_range(0, 1));
    endcase
    xs.r_data    = have_pending ? pending : DATA_W'($urandom);
    have_pending = 1'b0;
    xs.r_empty   = stuck || (q.size() == 0) || (full_mode == 2 && $urandom_range(0, 3) == 0);
    #1;
    if (!bus_rst) begin
      if (xs.w_full)  chk("no_wren_when_full", 64'(xs.w_wren), 0);
      if (xs.r_empty) chk("no_rden_when_empty", 64'(xs.r_rden), 0);
      if (xs.w_open && first_open_phase < 0) first_open_phase = phase;
      if (xs.w_wren) begin
        chk("w_data_seq", 64'(xs.w_data), 64'((n_wr % PL) + 1));
        q.push_back(xs.w_data);
        n_wr++;
        last_wr_phase = phase;
        if (first_wr_phase < 0) first_wr_phase = phase;
      end
      if (xs.r_rden && !xs.r_empty && q.size() > 0) begin
        pending      = q.pop_front();
        have_pending = 1'b1;
      end
    end
    phase++;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctrl"}, 64'({busy, done, timeout, xs.w_open, xs.w_wren, xs.r_open, xs.r_rden,
                               words_sent, words_recv}), 0);
    chk({name, "_data"}, {rx_sum, xs.w_data}, 0);
  endtask

  task automatic do_run(input vec_t v);
    int s;
    int done_phase;
    bit got_done;
    full_mode        = v.full_mode;
    stuck            = v.stuck;
    q.delete();
    have_pending     = 1'b0;
    n_wr             = 0;
    last_wr_phase    = -1;
    first_wr_phase   = -1;
    first_open_phase = -1;
    repeat (5) step();
    s         = phase;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    step();
    chk("busy_after_start", 64'({busy, xs.w_open}), 64'(2'b11));
    chk("cleared_after_start", 64'({done, timeout, words_sent, words_recv}), 0);
    got_done   = 1'b0;
    done_phase = -1;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      start_req = (v.poke_at > 0 && i == v.poke_at);
      step();
      start_req = 1'b0;
      if (v.rst_after > 0 && n_wr == v.rst_after) begin
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        q.delete();
        have_pending = 1'b0;
        step();
        check_zero("reset_abort");
        return;
      end
      if (done) begin
        got_done   = 1'b1;
        done_phase = phase - 1;
      end
    end
    chk("run_completes", 64'(got_done), 1);
    chk("timeout_flag", 64'(timeout), 64'(v.exp_to));
    chk("words_sent", 64'(words_sent), 64'(v.exp_sent));
    chk("words_recv", 64'(words_recv), 64'(v.exp_recv));
    chk("rx_sum", 64'(rx_sum), 64'(v.exp_sum));
    chk("streams_closed", 64'({busy, xs.w_open, xs.r_open}), 0);
    if (v.stuck)
      chk("timeout_latency", 64'(done_phase), 64'(last_wr_phase + 1 + TMO));
    if (v.check_timing) begin
      chk("first_w_open", 64'(first_open_phase), 64'(s + 1));
      chk("first_w_wren", 64'(first_wr_phase), 64'(s + 1 + OW));
      chk("contiguous_writes", 64'(last_wr_phase - first_wr_phase + 1), 64'(TOTAL));
    end
    step();
    chk("done_held", 64'({done, timeout}), 64'({1'b1, v.exp_to}));
  endtask

  initial begin
    ramp_sum = 0;
    for (int n = 0; n < TOTAL; n++) ramp_sum += (n % PL) + 1;

    vecs[0] = '{0, 0, 0, 0,  1, 0, TOTAL, EXP, ramp_sum};
    vecs[1] = '{1, 0, 0, 0,  0, 0, TOTAL, EXP, ramp_sum};
    vecs[2] = '{0, 1, 0, 0,  0, 1, TOTAL, 0,   0};
    vecs[3] = '{0, 0, 7, 0,  0, 0, 0,     0,   0};
    vecs[4] = '{0, 0, 0, 0,  1, 0, TOTAL, EXP, ramp_sum};
    vecs[5] = '{0, 0, 0, 20, 1, 0, TOTAL, EXP, ramp_sum};
    vecs[6] = '{2, 0, 0, 0,  0, 0, TOTAL, EXP, ramp_sum};
    vecs[7] = '{2, 0, 0, 0,  0, 0, TOTAL, EXP, ramp_sum};
    vecs[8] = '{2, 0, 0, 0,  0, 0, TOTAL, EXP, ramp_sum};
    vecs[9] = '{0, 0, 0, 0,  1, 0, TOTAL, EXP, ramp_sum};

    xs.w_full    = 1'b0;
    xs.r_empty   = 1'b1;
    xs.r_data    = '0;
    full_mode    = 0;
    stuck        = 1'b0;
    start_req    = 1'b0;
    rst_req      = 1'b1;
    phase        = 0;
    have_pending = 1'b0;
    repeat (3) step();
    rst_req = 1'b0;
    step();
    check_zero("reset_state");

    foreach (vecs[i]) do_run(vecs[i]);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
